high_freq_fir: RTL

Consumer side of the high-band sample queue: a stereo multiply-accumulate engine that takes the 1021-sample burst read out of the queue while `sequencing` is high and produces one filtered left/right sample pair per burst. Each sample is multiplied by a Q1.15 coefficient fetched from an external synchronous coefficient ROM. The block sits between the high-frequency queue and the band mixer/volume stage.

---
 rtl/high_freq_fir_if.sv | 22 ++
 rtl/high_freq_fir.sv | 138 +++++++++++++
 2 files changed

// File: rtl/high_freq_fir_if.sv
// Queue/ROM/output bundle for the high-band FIR engine.
interface high_freq_fir_if;
   logic        sequencing;
   logic [15:0] lft_in;
   logic [15:0] rght_in;
   logic [9:0]  coeff_addr;
   logic [15:0] coeff;
   logic [15:0] lft_out;
   logic [15:0] rght_out;
   logic        vld;
   logic        err;

   modport master (
      output sequencing, lft_in, rght_in, coeff,
      input  coeff_addr, lft_out, rght_out, vld, err
   );

   modport slave (
      input  sequencing, lft_in, rght_in, coeff,
      output coeff_addr, lft_out, rght_out, vld, err
   );
endinterface

// File: rtl/high_freq_fir.sv
// Stereo multiply-accumulate over one queue burst; one filtered L/R pair per burst.
module high_freq_fir #(
   parameter int unsigned NUM_TAPS = 1021
) (
   input logic             clk,
   input logic             rst_n,
   high_freq_fir_if.slave  bus
);

   logic [9:0]         tap_cnt_q, tap_cnt_d;
   logic               data_vld_q, data_vld_d;
   logic               prod_vld_q, prod_vld_d;
   logic               prod_vld_prev_q, prod_vld_prev_d;
   logic signed [31:0] prod_l_q, prod_l_d;
   logic signed [31:0] prod_r_q, prod_r_d;
   logic signed [41:0] acc_l_q, acc_l_d;
   logic signed [41:0] acc_r_q, acc_r_d;
   logic [9:0]         burst_cnt_q, burst_cnt_d;
   logic [15:0]        lft_out_q, lft_out_d;
   logic [15:0]        rght_out_q, rght_out_d;
   logic               vld_q, vld_d;
   logic               err_q, err_d;

   logic               burst_first;
   logic               burst_done;

   // Floor-divide by 2^15 and clamp into the 16-bit output range.
   function automatic logic [15:0] sat16(input logic signed [41:0] acc);
      logic signed [26:0] shifted;
      shifted = 27'(acc >>> 15);
      if (shifted > 27'sd32767)
         return 16'h7FFF;
      else if (shifted < -27'sd32768)
         return 16'h8000;
      else
         return shifted[15:0];
   endfunction

   // Coefficient address; parked at 0 whenever the queue is idle.
   assign bus.coeff_addr = bus.sequencing ? tap_cnt_q : '0;

   assign bus.lft_out  = lft_out_q;
   assign bus.rght_out = rght_out_q;
   assign bus.vld      = vld_q;
   assign bus.err      = err_q;

   assign burst_first = prod_vld_q & ~prod_vld_prev_q;
   assign burst_done  = prod_vld_prev_q & ~prod_vld_q;

   // Tap counter and alignment flags: coeff lands alongside the queue data.
   always_comb begin
      tap_cnt_d = '0;
      if (bus.sequencing) begin
         if (tap_cnt_q != 10'(NUM_TAPS - 1))
            tap_cnt_d = tap_cnt_q + 10'd1;
         else
            tap_cnt_d = tap_cnt_q;
      end
      data_vld_d      = bus.sequencing;
      prod_vld_d      = data_vld_q;
      prod_vld_prev_d = prod_vld_q;
   end

   // Stage 1: register per-channel products while data is aligned.
   always_comb begin
      prod_l_d = prod_l_q;
      prod_r_d = prod_r_q;
      if (data_vld_q) begin
         prod_l_d = $signed(bus.lft_in)  * $signed(bus.coeff);
         prod_r_d = $signed(bus.rght_in) * $signed(bus.coeff);
      end
   end

   // Stage 2: accumulate; the prod_vld rise restarts the sum so a following
   // burst can begin before the previous result has been unloaded.
   always_comb begin
      acc_l_d     = acc_l_q;
      acc_r_d     = acc_r_q;
      burst_cnt_d = burst_cnt_q;
      if (burst_first) begin
         acc_l_d     = 42'(prod_l_q);
         acc_r_d     = 42'(prod_r_q);
         burst_cnt_d = 10'd1;
      end else if (prod_vld_q) begin
         acc_l_d = acc_l_q + 42'(prod_l_q);
         acc_r_d = acc_r_q + 42'(prod_r_q);
         if (burst_cnt_q != 10'd1023)
            burst_cnt_d = burst_cnt_q + 10'd1;
      end
   end

   // Output load on the prod_vld fall; vld is a single-cycle strobe.
   always_comb begin
      lft_out_d  = lft_out_q;
      rght_out_d = rght_out_q;
      err_d      = err_q;
      vld_d      = burst_done;
      if (burst_done) begin
         lft_out_d  = sat16(acc_l_q);
         rght_out_d = sat16(acc_r_q);
         err_d      = (burst_cnt_q != 10'(NUM_TAPS));
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_cnt_q       <= '0;
         data_vld_q      <= 1'b0;
         prod_vld_q      <= 1'b0;
         prod_vld_prev_q <= 1'b0;
         prod_l_q        <= '0;
         prod_r_q        <= '0;
         acc_l_q         <= '0;
         acc_r_q         <= '0;
         burst_cnt_q     <= '0;
         lft_out_q       <= '0;
         rght_out_q      <= '0;
         vld_q           <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         tap_cnt_q       <= tap_cnt_d;
         data_vld_q      <= data_vld_d;
         prod_vld_q      <= prod_vld_d;
         prod_vld_prev_q <= prod_vld_prev_d;
         prod_l_q        <= prod_l_d;
         prod_r_q        <= prod_r_d;
         acc_l_q         <= acc_l_d;
         acc_r_q         <= acc_r_d;
         burst_cnt_q     <= burst_cnt_d;
         lft_out_q       <= lft_out_d;
         rght_out_q      <= rght_out_d;
         vld_q           <= vld_d;
         err_q           <= err_d;
      end
   end

endmodule
